pipe_stall_ctrl: RTL

Central stall controller for the five-stage pipeline. It detects load-use hazards between ID and EX, and sequences the iterative multi-cycle unit (mul/div) that sits in EX. From both it drives the shared `stall` bus consumed by PC, IF, ID, EX, MEM and WB. The block replaces the scattered per-stage `stallreq` wires with one arbitrated source of truth.

---
 rtl/pipe_stall_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall controller for the five-stage pipeline.
//
// Detects load-use hazards between ID and EX and sequences the iterative
// multi-cycle (mul/div) unit in EX. Both sources are merged into one shared
// stall bus. A multi-cycle request in EX beats a load-use hazard because EX
// holds the older instruction.
//
// Optional feature macro: PERF_CNT_EN
//   defined   -> saturating 32-bit stall-cycle counters lu_cnt / mc_cnt
//   undefined -> lu_cnt / mc_cnt tied to zero, no counter flops
//
// Parameters:
//   MC_LAT       cycles from mc_start to mc_done (legal 2..63)
// Ports:
//   clk          pipeline clock
//   rst          synchronous active-high reset
//   id_rs/id_rt  source register fields of the ID instruction
//   id_rs_rd     ID instruction reads rs
//   id_rt_rd     ID instruction reads rt
//   ex_is_load   EX instruction is a load
//   ex_rf_we     EX instruction writes the regfile
//   ex_rf_waddr  EX destination register
//   ex_mc_req    level: a multi-cycle op is resident in EX
//   stall        {WB, MEM, EX, ID, IF, PC}, 1 = stop
//   mc_start     one-cycle launch pulse for the multi-cycle unit
//   mc_done      one-cycle pulse, unit result valid, EX latches it
//   mc_busy      high while the multi-cycle sequence is running
//   lu_cnt       load-use stall cycle count
//   mc_cnt       multi-cycle stall cycle count
module pipe_stall_ctrl #(
  parameter int unsigned MC_LAT = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_rd,
  input  logic        id_rt_rd,
  input  logic        ex_is_load,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_mc_req,
  output logic [5:0]  stall,
  output logic        mc_start,
  output logic        mc_done,
  output logic        mc_busy,
  output logic [31:0] lu_cnt,
  output logic [31:0] mc_cnt
);

  localparam logic [5:0] StallLu = 6'b000111;  // hold PC/IF/ID, bubble into EX
  localparam logic [5:0] StallMc = 6'b001111;  // hold through EX
  localparam logic [5:0] LastCnt = 6'(MC_LAT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMcRun,
    StMcDone
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       lu;

  // Writes to $0 are discarded, so they never create a dependency.
  assign lu = ex_is_load & ex_rf_we & (ex_rf_waddr != 5'd0) &
              ((id_rs_rd & (id_rs == ex_rf_waddr)) |
               (id_rt_rd & (id_rt == ex_rf_waddr)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 6'b000000;
    mc_start = 1'b0;
    mc_done  = 1'b0;
    mc_busy  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_mc_req) begin
          stall    = StallMc;
          mc_start = 1'b1;
          cnt_d    = 6'd1;
          state_d  = StMcRun;
        end else if (lu) begin
          stall = StallLu;
        end
      end
      StMcRun: begin
        // ex_mc_req is not looked at: once launched the sequence completes.
        stall   = StallMc;
        mc_busy = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == LastCnt) begin
          state_d = StMcDone;
        end
      end
      StMcDone: begin
        // EX advances with the result; a pending ex_mc_req here belongs to
        // the finishing op and is ignored.
        mc_done = 1'b1;
        state_d = StIdle;
        if (lu) begin
          stall = StallLu;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (rst) begin
      stall    = 6'b000000;
      mc_start = 1'b0;
      mc_done  = 1'b0;
      mc_busy  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] lu_cnt_q, mc_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q <= 32'd0;
      mc_cnt_q <= 32'd0;
    end else begin
      if ((stall == StallLu) && (lu_cnt_q != 32'hFFFF_FFFF)) begin
        lu_cnt_q <= lu_cnt_q + 32'd1;
      end
      if ((stall == StallMc) && (mc_cnt_q != 32'hFFFF_FFFF)) begin
        mc_cnt_q <= mc_cnt_q + 32'd1;
      end
    end
  end

  assign lu_cnt = lu_cnt_q;
  assign mc_cnt = mc_cnt_q;
`else
  assign lu_cnt = 32'd0;
  assign mc_cnt = 32'd0;
`endif

endmodule
